// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle instruction sequencer with shared memory port and stack pointer
module instr_sequencer #(
  parameter int              SP_W    = 8,
  parameter logic [SP_W-1:0] SP_INIT = 8'hFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            reg_write_i,
  input  logic            pc_src_i,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [1:0]      mem_addr_sel,
  output logic [SP_W-1:0] stk_addr,
  output logic            ir_load,
  output logic            pc_load,
  output logic [1:0]      pc_sel,
  output logic            reg_we,
  output logic [SP_W-1:0] sp,
  output logic            halted,
  output logic            fault,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_STK = 2'b10;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_TGT = 2'b01;
  localparam logic [1:0] PC_RET = 2'b10;

  state_t          state_q;
  logic [SP_W-1:0] sp_q;

  // Operation captured in EXEC so MEM does not depend on the decoder holding its levels.
  logic op_load;
  logic op_store;
  logic op_push;
  logic op_pop;

  logic [2:0] op_cnt;
  logic       exec_illegal;
  logic       exec_overflow;
  logic       exec_underflow;
  logic       exec_fault;
  logic       exec_mem;

  assign state    = state_q;
  assign sp       = sp_q;
  // Push writes at sp then decrements; pop increments then reads, hence sp+1.
  assign stk_addr = op_push ? sp_q : sp_q + 1'b1;

  assign op_cnt         = {2'b00, mem_read_i} + {2'b00, mem_write_i} + {2'b00, push_i} + {2'b00, pop_i};
  assign exec_illegal   = (op_cnt > 3'd1);
  assign exec_overflow  = push_i && (sp_q == '0);
  assign exec_underflow = pop_i && (sp_q == SP_INIT);
  assign exec_fault     = exec_illegal || exec_overflow || exec_underflow;
  assign exec_mem       = mem_read_i || mem_write_i || push_i || pop_i;

  // Sequencer state, stack pointer and registered memory-port controls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sp_q         <= SP_INIT;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr_sel <= SEL_PC;
      halted       <= 1'b0;
      fault        <= 1'b0;
      op_load      <= 1'b0;
      op_store     <= 1'b0;
      op_push      <= 1'b0;
      op_pop       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_FETCH;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr_sel <= SEL_PC;
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            state_q <= S_DECODE;
            mem_req <= 1'b0;
          end
        end
        S_DECODE: begin
          if (halt_i) begin
            state_q <= S_HALT;
            halted  <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          op_load  <= mem_read_i;
          op_store <= mem_write_i;
          op_push  <= push_i;
          op_pop   <= pop_i;
          if (exec_fault) begin
            state_q <= S_FAULT;
            fault   <= 1'b1;
          end else if (exec_mem) begin
            state_q      <= S_MEM;
            mem_req      <= 1'b1;
            mem_we       <= mem_write_i || push_i;
            mem_addr_sel <= (push_i || pop_i) ? SEL_STK : SEL_ALU;
          end else if (reg_write_i) begin
            state_q <= S_WB;
          end else begin
            state_q      <= S_FETCH;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr_sel <= SEL_PC;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_we       <= 1'b0;
            mem_addr_sel <= SEL_PC;
            if (op_load) begin
              state_q <= S_WB;
              mem_req <= 1'b0;
            end else begin
              if (op_push) sp_q <= sp_q - 1'b1;
              if (op_pop)  sp_q <= sp_q + 1'b1;
              state_q <= S_FETCH;
              mem_req <= 1'b1;
            end
          end
        end
        S_WB: begin
          state_q      <= S_FETCH;
          mem_req      <= 1'b1;
          mem_we       <= 1'b0;
          mem_addr_sel <= SEL_PC;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FAULT;
          mem_req <= 1'b0;
          fault   <= 1'b1;
        end
      endcase
    end
  end

  // One-cycle strobes decoded in the cycle of the handshake/decision so the IR, PC
  // and register file capture while the memory data and next-PC select are valid.
  always_comb begin
    ir_load = 1'b0;
    pc_load = 1'b0;
    pc_sel  = PC_INC;
    reg_we  = 1'b0;
    case (state_q)
      S_FETCH: ir_load = mem_ready;
      S_EXEC: begin
        if (!exec_fault && !exec_mem && !reg_write_i) begin
          pc_load = 1'b1;
          pc_sel  = pc_src_i ? PC_TGT : PC_INC;
        end
      end
      S_MEM: begin
        if (mem_ready && !op_load) begin
          pc_load = 1'b1;
          if (op_push)     pc_sel = PC_TGT;
          else if (op_pop) pc_sel = PC_RET;
          else             pc_sel = PC_INC;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_load = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, halt_i, mem_read_i, mem_write_i, push_i, pop_i;
  logic       reg_write_i, pc_src_i, mem_ready;
  logic       mem_req, mem_we, ir_load, pc_load, reg_we, halted, fault;
  logic [1:0] mem_addr_sel, pc_sel;
  logic [7:0] stk_addr, sp;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;
  int cnt;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .halt_i(halt_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .push_i(push_i), .pop_i(pop_i),
    .reg_write_i(reg_write_i), .pc_src_i(pc_src_i), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .stk_addr(stk_addr),
    .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel), .reg_we(reg_we),
    .sp(sp), .halted(halted), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    start = 0; halt_i = 0; mem_read_i = 0; mem_write_i = 0; push_i = 0; pop_i = 0;
    reg_write_i = 0; pc_src_i = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_sp", sp, 8'hFF);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stk_addr", stk_addr, 0);
    chk("rst_flags", {halted, fault, ir_load, pc_load, reg_we}, 0);

    // ALU op, zero-wait memory
    start = 1; mem_ready = 1; reg_write_i = 1;
    cyc(); start = 0; #1;
    chk("add_c1_state", state, 1);
    chk("add_c1_fetch", {mem_req, mem_we, mem_addr_sel, ir_load}, 5'b1_0_00_1);
    cyc();
    chk("add_c2_state", state, 2);
    chk("add_c2_quiet", {mem_req, ir_load}, 0);
    cyc();
    chk("add_c3_state", state, 3);
    chk("add_c3_nostrobe", {pc_load, reg_we}, 0);
    mem_ready = 0;
    cyc();
    chk("add_c4_state", state, 5);
    chk("add_c4_strobes", {reg_we, pc_load, pc_sel}, 4'b1_1_00);

    // FETCH with three wait cycles
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wait_fetch", {state, mem_req, mem_addr_sel}, {3'd1, 1'b1, 2'b00});
      if (ir_load) cnt++;
    end
    mem_ready = 1; #1;
    chk("wait_ack", {state, mem_req, mem_addr_sel, ir_load}, {3'd1, 1'b1, 2'b00, 1'b1});
    cnt++;
    cyc();
    chk("wait_irload_once", cnt, 1);
    chk("wait_decode", {state, mem_req}, {3'd2, 1'b0});

    // taken branch: 3 cycles, pc_load in EXEC
    reg_write_i = 0; pc_src_i = 1;
    cyc();
    chk("br_exec", {state, pc_load, pc_sel}, {3'd3, 1'b1, 2'b01});
    pc_src_i = 0;
    cyc();
    chk("br_fetch", {state, mem_req}, {3'd1, 1'b1});

    // call
    cyc();
    push_i = 1; pc_src_i = 1;
    cyc();
    chk("call_exec", {state, pc_load}, {3'd3, 1'b0});
    cyc();
    chk("call_mem", {state, mem_req, mem_we, mem_addr_sel}, {3'd4, 1'b1, 1'b1, 2'b10});
    chk("call_addr", stk_addr, 8'hFF);
    chk("call_pc", {pc_load, pc_sel}, 3'b1_01);
    chk("call_sp_pre", sp, 8'hFF);
    push_i = 0; pc_src_i = 0;
    cyc();
    chk("call_sp_post", {state, sp}, {3'd1, 8'hFE});

    // ret
    cyc();
    pop_i = 1;
    cyc();
    cyc();
    chk("ret_mem", {state, mem_req, mem_we, mem_addr_sel}, {3'd4, 1'b1, 1'b0, 2'b10});
    chk("ret_addr", stk_addr, 8'hFF);
    chk("ret_pc", {pc_load, pc_sel}, 3'b1_10);
    pop_i = 0;
    cyc();
    chk("ret_sp_post", {state, sp}, {3'd1, 8'hFF});

    // store with one wait cycle in MEM
    cyc();
    mem_write_i = 1;
    cyc();
    mem_ready = 0;
    cyc();
    chk("st_mem", {state, mem_req, mem_we, mem_addr_sel, pc_load}, {3'd4, 1'b1, 1'b1, 2'b01, 1'b0});
    mem_write_i = 0;
    cyc();
    chk("st_hold", {state, mem_req, mem_we, mem_addr_sel}, {3'd4, 1'b1, 1'b1, 2'b01});
    mem_ready = 1; #1;
    chk("st_ack", {pc_load, pc_sel}, 3'b1_00);
    cyc();
    chk("st_fetch", state, 1);

    // load
    cyc();
    mem_read_i = 1; reg_write_i = 1;
    cyc();
    cyc();
    chk("ld_mem", {state, mem_we, mem_addr_sel, pc_load}, {3'd4, 1'b0, 2'b01, 1'b0});
    mem_read_i = 0; reg_write_i = 0;
    cyc();
    chk("ld_wb", {state, reg_we, pc_load, mem_req}, {3'd5, 1'b1, 1'b1, 1'b0});
    cyc();

    // illegal combination
    cyc();
    mem_read_i = 1; mem_write_i = 1;
    cyc();
    cyc();
    chk("ill_fault", {state, fault, mem_req, pc_load}, {3'd7, 1'b1, 1'b0, 1'b0});

    // pop at empty stack
    do_reset();
    start = 1; mem_ready = 1;
    cyc(); start = 0;
    cyc();
    pop_i = 1;
    cyc();
    cyc();
    chk("under_fault", {state, fault, mem_req, sp}, {3'd7, 1'b1, 1'b0, 8'hFF});
    start = 1;
    cyc();
    chk("under_sticky", {state, fault, mem_req}, {3'd7, 1'b1, 1'b0});

    // 256 pushes from FF
    do_reset();
    start = 1; mem_ready = 1; push_i = 1; pc_src_i = 1;
    cyc(); start = 0;
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      cyc();
      cyc();
      cyc();
      if (state == 3'd4) begin
        cnt++;
        cyc();
      end
    end
    chk("over_count", cnt, 255);
    chk("over_fault", {state, fault, sp}, {3'd7, 1'b1, 8'h00});

    // halt
    do_reset();
    start = 1; mem_ready = 1; halt_i = 1;
    cyc(); start = 0;
    cyc();
    cyc();
    chk("halt_state", {state, halted, fault}, {3'd6, 1'b1, 1'b0});
    cnt = 0;
    start = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (mem_req || ir_load || pc_load || reg_we) cnt++;
    end
    chk("halt_quiet", cnt, 0);

    // async reset mid-MEM
    do_reset();
    start = 1; mem_ready = 1; push_i = 1;
    cyc(); start = 0;
    cyc();
    mem_ready = 0;
    cyc();
    cyc();
    chk("mid_mem", {state, mem_req}, {3'd4, 1'b1});
    reset = 0; #1;
    chk("mid_rst", {state, mem_req, mem_we, sp}, {3'd0, 1'b0, 1'b0, 8'hFF});
    reset = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
